prefetch_align_stage: RTL and testbench
=======================================

PREFETCH_ALIGN_STAGE -- requirements
Module: prefetch_align_stage

Interface
REQ-001 Parameter: DEPTH, default 4, number of 32-bit word entries in the prefetch queue; SHALL be a power of two in 2..16.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 Port: clk, input, 1, single clock; all state SHALL be updated on posedge clk.
REQ-004 Port: rst, input, 1, asynchronous, active-low reset.
REQ-005 Port: redir_valid, input, 1, redirect request (exception, mret or jump, already prioritised upstream).
REQ-006 Port: redir_pc, input, 32, redirect target; bit 0 SHALL be ignored and treated as 0.
REQ-007 Port: mem_valid, output, 1, fetch request valid.
REQ-008 Port: mem_addr, output, 32, word-aligned fetch address; bits [1:0] SHALL always be 0.
REQ-009 Port: mem_instr, output, 1, constant 1.
REQ-010 Port: mem_ready, input, 1, request completes this cycle; mem_rdata is valid this cycle.
REQ-011 Port: mem_rdata, input, 32, returned instruction word.
REQ-012 Port: out_valid, output, 1, aligned instruction available to decode.
REQ-013 Port: out_ready, input, 1, decode accepts the instruction this cycle.
REQ-014 Port: out_pc, output, 32, halfword-aligned PC of out_instr.
REQ-015 Port: out_instr, output, 32, instruction; for a 16-bit instruction, bits [31:16] SHALL be 0.

Function
REQ-016 State: fetch pointer fpc (word address), decode PC dpc, DEPTH-entry word FIFO, occupancy count, one pending-request flag, one discard flag.
REQ-017 At most one memory request SHALL be outstanding; mem_valid and mem_addr SHALL be registered and held stable until the cycle mem_ready=1.
REQ-018 A new request SHALL be issued in the cycle after completion, or after reset/redirect, only if occupancy plus pending < DEPTH, counting a same-cycle pop.
REQ-019 On completion without discard, mem_rdata SHALL be pushed to the FIFO tail, and fpc SHALL advance by 4 with 32-bit wrap-around.
REQ-020 Alignment: if dpc[1]=0, the candidate halfword is head[15:0]; if dpc[1]=1, it is head[31:16].
REQ-021 If candidate[1:0]!=2'b11, out_instr SHALL be {16'h0, candidate}, and out_valid SHALL require occupancy>=1.
REQ-022 If candidate[1:0]==2'b11 and dpc[1]=0, out_instr SHALL be head, and out_valid SHALL require occupancy>=1.
REQ-023 If candidate[1:0]==2'b11 and dpc[1]=1, out_instr SHALL be {entry1[15:0], head[31:16]}, and out_valid SHALL require occupancy>=2.
REQ-024 out_valid, out_pc and out_instr SHALL be combinational from registered state only, not from mem_ready or redir_valid.
REQ-025 On handshake (out_valid & out_ready), dpc SHALL advance by 2 or 4.
REQ-026 On handshake, the FIFO SHALL pop one word when dpc crosses into the next word, and two words never.
REQ-027 A 32-bit instruction spanning words SHALL pop only the first word.
REQ-028 Full FIFO: no request SHALL be issued; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-029 Redirect: next cycle, FIFO SHALL be empty, dpc={redir_pc[31:1],1'b0}, fpc={redir_pc[31:2],2'b00}, and out_valid=0.
REQ-030 Redirect with a request pending and mem_ready=0: discard SHALL be set; the held request SHALL complete unchanged, its data SHALL be dropped, and the redirect fetch SHALL be issued after it.
REQ-031 Redirect in the same cycle as mem_ready=1: the returned data SHALL be dropped.
REQ-032 Redirect in the same cycle as a handshake: the handshake counts for decode; the flush SHALL take precedence for internal state.
REQ-033 A redirect to dpc[1]=1 SHALL ignore the lower halfword of the first fetched word.

Reset
REQ-034 While rst=0: mem_valid=0, out_valid=0, FIFO empty, pending=0, discard=0, dpc=RESET_PC, fpc=RESET_PC&~3.
REQ-035 In the first cycle after rst rises, mem_valid=1 and mem_addr=RESET_PC&~3.
REQ-036 Reset asserted mid-request SHALL abandon the request with no data pushed.

Verification
REQ-037 Reset, memory returns 0x00000013 and 0x00A00093 with zero wait, out_ready=1 -> out (pc,instr)=(0x0,0x00000013), then (0x4,0x00A00093).
REQ-038 Word 0x45014505 (two RVC) -> out (0x0,0x00004505), then (0x2,0x00004501); one pop.
REQ-039 Redirect to 0x102, words @0x100=0x0013_4501, @0x104=0xABCD_0000 -> out (0x102,0x00000013), then (0x106,0x0000ABCD). The 32-bit spanning case uses {entry1[15:0],head[31:16]}.
REQ-040 out_ready=0 for 20 cycles with DEPTH=4 -> exactly 4 requests complete, then mem_valid=0; occupancy never exceeds 4.
REQ-041 Redirect to 0x200 while a request to 0x8 is pending with 3 wait cycles -> 0x8 data is dropped, the next mem_addr is 0x200, and no instruction from 0x8 appears on out.
REQ-042 rst pulsed low mid-request -> outputs go to reset values asynchronously, and the first request after release is to RESET_PC.

Source files
------------

// File: rtl/prefetch_align_stage_if.sv
// Fetch-side bus between the prefetch/align stage, instruction memory, decode and redirect logic.
// The stage itself connects through the master modport; the environment uses slave.
interface prefetch_align_stage_if;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    input  redir_valid, redir_pc, mem_ready, mem_rdata, out_ready,
    output mem_valid, mem_addr, mem_instr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redir_valid, redir_pc, mem_ready, mem_rdata, out_ready,
    input  mem_valid, mem_addr, mem_instr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/prefetch_align_stage.sv
// Instruction prefetch queue with RVC halfword alignment: fetches words into a small FIFO
// and presents 16/32-bit instructions at the decode PC, with redirect flush and stale-data discard.
module prefetch_align_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                    clk,
  input logic                    rst,
  prefetch_align_stage_if.master bus
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [31:0] RESET_FPC = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]   fifo_q [DEPTH];
  logic [31:0]   fifo_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   dpc_q, dpc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          pend_q, pend_d;
  logic          discard_q, discard_d;

  logic [31:0]   head_s;
  logic [31:0]   entry1_s;
  logic [15:0]   cand_s;
  logic          is32_s;
  logic          out_valid_s;
  logic [31:0]   out_instr_s;
  logic          hs_s;
  logic          complete_s;
  logic          push_s;
  logic          pop_s;
  logic          slot_free_s;

  // Alignment: pick the halfword at dpc and decide whether a full instruction is buffered.
  always_comb begin
    head_s   = fifo_q[rd_ptr_q];
    entry1_s = fifo_q[rd_ptr_q + PONE_C];
    cand_s   = dpc_q[1] ? head_s[31:16] : head_s[15:0];
    is32_s   = (cand_s[1:0] == 2'b11);
    if (!is32_s) begin
      out_instr_s = {16'h0000, cand_s};
      out_valid_s = (count_q >= ONE_C);
    end else if (!dpc_q[1]) begin
      out_instr_s = head_s;
      out_valid_s = (count_q >= ONE_C);
    end else begin
      out_instr_s = {entry1_s[15:0], head_s[31:16]};
      out_valid_s = (count_q >= TWO_C);
    end
  end

  // Next-state: FIFO push/pop, PC tracking, redirect flush and request issue.
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fpc_d      = fpc_q;
    dpc_d      = dpc_q;
    discard_d  = discard_q;
    pend_d     = pend_q;
    mem_addr_d = mem_addr_q;

    hs_s        = out_valid_s & bus.out_ready;
    complete_s  = pend_q & bus.mem_ready;
    slot_free_s = ~pend_q | bus.mem_ready;
    push_s      = complete_s & ~discard_q & ~bus.redir_valid;
    // A spanning 32-bit instruction only retires its first word; the second stays as new head.
    pop_s       = hs_s & (is32_s | dpc_q[1]) & ~bus.redir_valid;

    if (bus.redir_valid) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      dpc_d     = bus.redir_pc & 32'hFFFF_FFFE;
      fpc_d     = bus.redir_pc & 32'hFFFF_FFFC;
      discard_d = pend_q & ~bus.mem_ready;
    end else begin
      if (push_s) begin
        fifo_d[wr_ptr_q] = bus.mem_rdata;
        wr_ptr_d         = wr_ptr_q + PONE_C;
        fpc_d            = fpc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (complete_s) begin
        discard_d = 1'b0;
      end else begin
        discard_d = discard_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (hs_s) begin
        dpc_d = dpc_q + (is32_s ? 32'd4 : 32'd2);
      end else begin
        dpc_d = dpc_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    // The request address is held until completion; a discarded completion refetches at fpc.
    if (slot_free_s) begin
      if (count_d < DEPTH_C) begin
        pend_d     = 1'b1;
        mem_addr_d = fpc_d;
      end else begin
        pend_d     = 1'b0;
        mem_addr_d = mem_addr_q;
      end
    end else begin
      pend_d     = pend_q;
      mem_addr_d = mem_addr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 32'h0000_0000;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fpc_q      <= RESET_FPC;
      dpc_q      <= RESET_PC;
      mem_addr_q <= RESET_FPC;
      pend_q     <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fpc_q      <= fpc_d;
      dpc_q      <= dpc_d;
      mem_addr_q <= mem_addr_d;
      pend_q     <= pend_d;
      discard_q  <= discard_d;
    end
  end

  assign bus.mem_valid = pend_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_instr = 1'b1;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = dpc_q;
  assign bus.out_instr = out_instr_s;

endmodule

// File: tb/tb_prefetch_align_stage.sv
// Directed bench for prefetch_align_stage: a wait-state memory responder plus a linear
// sequence of steps with hand-computed expected PCs, instructions and request addresses.
module tb_prefetch_align_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks      = 0;
  int   errors      = 0;
  int   completions = 0;
  int   wait_cycles = 0;
  int   wcnt        = 0;
  int   base        = 0;
  logic found;
  logic [31:0] mem [logic [31:0]];

  prefetch_align_stage_if bus ();

  prefetch_align_stage #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return 32'h0000_0013;
  endfunction

  // Memory responder: answers the held request after wait_cycles idle negedges.
  always @(negedge clk) begin
    if (!rst) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0000_0000;
      wcnt = 0;
    end else begin
      if (bus.mem_ready) wcnt = 0;
      if (bus.mem_valid && wcnt >= wait_cycles) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
      end else begin
        bus.mem_ready = 1'b0;
        if (bus.mem_valid) wcnt = wcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && bus.mem_valid && bus.mem_ready) completions = completions + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0000_0000;
    bus.out_ready   = 1'b0;
    mem[32'h0000_0000] = 32'h0000_0013;
    mem[32'h0000_0004] = 32'h00A0_0093;
    mem[32'h0000_0008] = 32'h0088_0093;
    mem[32'h0000_0010] = 32'h4501_4505;
    mem[32'h0000_0014] = 32'h00B0_0113;
    mem[32'h0000_0100] = 32'h0013_4501;
    mem[32'h0000_0104] = 32'hABCD_0000;
    mem[32'h0000_0200] = 32'h0200_0093;
    mem[32'h0000_0304] = 32'h00C0_0193;

    step();
    step();
    check("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pc", bus.out_pc, 32'h0000_0000);
    check("mem_instr", 32'(bus.mem_instr), 32'd1);

    // Zero-wait straight-line fetch
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("first_req_valid", 32'(bus.mem_valid), 32'd1);
    check("first_req_addr", bus.mem_addr, 32'h0000_0000);
    step();
    check("out0_valid", 32'(bus.out_valid), 32'd1);
    check("out0_pc", bus.out_pc, 32'h0000_0000);
    check("out0_instr", bus.out_instr, 32'h0000_0013);
    step();
    check("out1_valid", 32'(bus.out_valid), 32'd1);
    check("out1_pc", bus.out_pc, 32'h0000_0004);
    check("out1_instr", bus.out_instr, 32'h00A0_0093);

    // Two compressed instructions in one word
    bus.out_ready   = 1'b0;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0010;
    step();
    bus.redir_valid = 1'b0;
    check("redir_out_valid", 32'(bus.out_valid), 32'd0);
    check("redir_mem_addr", bus.mem_addr, 32'h0000_0010);
    step();
    check("rvc0_valid", 32'(bus.out_valid), 32'd1);
    check("rvc0_pc", bus.out_pc, 32'h0000_0010);
    check("rvc0_instr", bus.out_instr, 32'h0000_4505);
    bus.out_ready = 1'b1;
    step();
    check("rvc1_pc", bus.out_pc, 32'h0000_0012);
    check("rvc1_instr", bus.out_instr, 32'h0000_4501);
    step();
    check("after_rvc_pc", bus.out_pc, 32'h0000_0014);
    check("after_rvc_instr", bus.out_instr, 32'h00B0_0113);

    // Redirect (odd target, bit 0 ignored) together with a handshake; spanning 32-bit instruction
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0103;
    step();
    bus.redir_valid = 1'b0;
    check("span_flush_valid", 32'(bus.out_valid), 32'd0);
    check("span_fetch_addr", bus.mem_addr, 32'h0000_0100);
    step();
    check("span_wait_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("span_valid", 32'(bus.out_valid), 32'd1);
    check("span_pc", bus.out_pc, 32'h0000_0102);
    check("span_instr", bus.out_instr, 32'h0000_0013);
    step();
    check("after_span_pc", bus.out_pc, 32'h0000_0106);
    check("after_span_instr", bus.out_instr, 32'h0000_ABCD);

    // Decode stalled: the queue fills to DEPTH and requests stop
    bus.out_ready   = 1'b0;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0300;
    step();
    bus.redir_valid = 1'b0;
    base = completions;
    repeat (20) step();
    check("full_completions", 32'(completions - base), 32'd4);
    check("full_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_out_pc", bus.out_pc, 32'h0000_0300);
    bus.out_ready = 1'b1;
    step();
    check("drain_pc", bus.out_pc, 32'h0000_0304);
    check("drain_instr", bus.out_instr, 32'h00C0_0193);
    check("drain_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("drain_mem_addr", bus.mem_addr, 32'h0000_0310);

    // Redirect while a wait-stated request to 0x8 is outstanding
    wait_cycles     = 3;
    bus.out_ready   = 1'b0;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0008;
    step();
    bus.redir_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_valid && bus.mem_addr == 32'h0000_0008) found = 1'b1;
      else step();
    end
    check("req8_seen", 32'(found), 32'd1);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0200;
    step();
    bus.redir_valid = 1'b0;
    check("disc_hold_valid", 32'(bus.mem_valid), 32'd1);
    check("disc_hold_addr1", bus.mem_addr, 32'h0000_0008);
    check("disc_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("disc_hold_addr2", bus.mem_addr, 32'h0000_0008);
    step();
    check("disc_hold_addr3", bus.mem_addr, 32'h0000_0008);
    step();
    check("redir_fetch_valid", 32'(bus.mem_valid), 32'd1);
    check("redir_fetch_addr", bus.mem_addr, 32'h0000_0200);
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid) found = 1'b1;
      else step();
    end
    bus.out_ready = 1'b0;
    check("redir_out_seen", 32'(found), 32'd1);
    check("redir_out_pc", bus.out_pc, 32'h0000_0200);
    check("redir_out_instr", bus.out_instr, 32'h0200_0093);

    // Asynchronous reset in the middle of an outstanding request
    check("pre_rst_mem_valid", 32'(bus.mem_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'h0000_0000);
    check("rst_mem_addr", bus.mem_addr, 32'h0000_0000);
    step();
    step();
    rst = 1'b1;
    wait_cycles = 0;
    step();
    check("rel_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("rel_mem_addr", bus.mem_addr, 32'h0000_0000);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("rel_out_valid2", 32'(bus.out_valid), 32'd1);
    check("rel_out_pc", bus.out_pc, 32'h0000_0000);
    check("rel_out_instr", bus.out_instr, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
